// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared types and widths for the MEM stage
package mem_access_stage_pkg;
  localparam int XLEN            = 64;
  localparam int REGADDR_W       = 5;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;
endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - request/acknowledge data-memory port
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// rtl/mem_access_stage_mem_wb_reg.sv - MEM/WB pipeline register with load and bubble
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetl,
  input  logic                 load,
  input  logic                 bubble,
  input  logic                 reg_write,
  input  logic                 mem2reg,
  input  logic [REGADDR_W-1:0] rd,
  input  logic [XLEN-1:0]      alu_out,
  input  logic [XLEN-1:0]      mem_data,
  output logic                 reg_write_q,
  output logic                 mem2reg_q,
  output logic [REGADDR_W-1:0] rd_q,
  output logic [XLEN-1:0]      alu_out_q,
  output logic [XLEN-1:0]      mem_data_q
);
  // Bubble takes priority so a stalled access can never leak a half-done write-back.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      reg_write_q <= 1'b0;
      mem2reg_q   <= 1'b0;
      rd_q        <= '0;
      alu_out_q   <= '0;
      mem_data_q  <= '0;
    end else if (bubble) begin
      reg_write_q <= 1'b0;
      mem2reg_q   <= 1'b0;
      rd_q        <= '0;
      alu_out_q   <= '0;
      mem_data_q  <= '0;
    end else if (load) begin
      reg_write_q <= reg_write;
      mem2reg_q   <= mem2reg;
      rd_q        <= rd;
      alu_out_q   <= alu_out;
      mem_data_q  <= mem_data;
    end
  end
endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: branch resolve, bounded-wait load/store, MEM/WB drive
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 resetl,
  input  logic                 RegWrite_MEM,
  input  logic                 Mem2Reg_MEM,
  input  logic                 MemRead_MEM,
  input  logic                 MemWrite_MEM,
  input  logic                 Branch_MEM,
  input  logic                 Uncondbranch_MEM,
  input  logic                 ALUzero_MEM,
  input  logic [REGADDR_W-1:0] RD_MEM,
  input  logic [XLEN-1:0]      ALUout_MEM,
  input  logic [XLEN-1:0]      RegOutB_MEM,
  input  logic [XLEN-1:0]      PCtarget_MEM,
  output logic                 PCSrc,
  output logic [XLEN-1:0]      PCtarget,
  output logic                 stall_MEM,
  output logic                 RegWrite_WB,
  output logic                 Mem2Reg_WB,
  output logic [REGADDR_W-1:0] RD_WB,
  output logic [XLEN-1:0]      ALUout_WB,
  output logic [XLEN-1:0]      MemData_WB,
  output logic                 mem_err,
  mem_access_stage_if.master   dmem
);
  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, next_state;
  logic [CW-1:0] cnt, cnt_next;
  logic          mem_op, misaligned;
  logic          req, we, stall, wb_load, wb_bubble, err_set, use_rdata;

  assign mem_op     = MemRead_MEM | MemWrite_MEM;
  assign misaligned = mem_op & (ALUout_MEM[2:0] != 3'b000);

  assign PCSrc    = Uncondbranch_MEM | (Branch_MEM & ALUzero_MEM);
  assign PCtarget = PCtarget_MEM;

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (err_set) mem_err <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    req        = 1'b0;
    we         = 1'b0;
    stall      = 1'b0;
    wb_load    = 1'b0;
    wb_bubble  = 1'b0;
    err_set    = 1'b0;
    use_rdata  = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          wb_load = 1'b1;
        end else if (misaligned) begin
          wb_bubble = 1'b1;
          err_set   = 1'b1;
        end else begin
          req        = 1'b1;
          we         = MemWrite_MEM;
          stall      = 1'b1;
          wb_bubble  = 1'b1;
          cnt_next   = '0;
          next_state = WAIT;
        end
      end
      WAIT: begin
        req = 1'b1;
        we  = MemWrite_MEM;
        // Ack is checked before the timeout so a last-cycle ack still completes cleanly.
        if (dmem.dmem_ack) begin
          wb_load    = 1'b1;
          use_rdata  = MemRead_MEM;
          next_state = IDLE;
        end else if (cnt == CNT_LAST) begin
          wb_bubble  = 1'b1;
          err_set    = 1'b1;
          next_state = IDLE;
        end else begin
          stall     = 1'b1;
          wb_bubble = 1'b1;
          cnt_next  = cnt + 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign stall_MEM       = stall;
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = we;
  assign dmem.dmem_addr  = ALUout_MEM;
  assign dmem.dmem_wdata = RegOutB_MEM;

  mem_wb_reg u_mem_wb_reg (
    .clk         (clk),
    .resetl      (resetl),
    .load        (wb_load),
    .bubble      (wb_bubble),
    .reg_write   (RegWrite_MEM),
    .mem2reg     (Mem2Reg_MEM),
    .rd          (RD_MEM),
    .alu_out     (ALUout_MEM),
    .mem_data    (use_rdata ? dmem.dmem_rdata : '0),
    .reg_write_q (RegWrite_WB),
    .mem2reg_q   (Mem2Reg_WB),
    .rd_q        (RD_WB),
    .alu_out_q   (ALUout_WB),
    .mem_data_q  (MemData_WB)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed bench with a cycle-level behavioural model
module tb_mem_access_stage;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetl = 1'b0;
  logic        RegWrite_MEM = 0, Mem2Reg_MEM = 0, MemRead_MEM = 0, MemWrite_MEM = 0;
  logic        Branch_MEM = 0, Uncondbranch_MEM = 0, ALUzero_MEM = 0;
  logic [4:0]  RD_MEM = '0;
  logic [63:0] ALUout_MEM = '0, RegOutB_MEM = '0, PCtarget_MEM = '0;
  logic        PCSrc, stall_MEM, RegWrite_WB, Mem2Reg_WB, mem_err;
  logic [63:0] PCtarget, ALUout_WB, MemData_WB;
  logic [4:0]  RD_WB;

  mem_access_stage_if dmem_bus ();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetl(resetl),
    .RegWrite_MEM(RegWrite_MEM), .Mem2Reg_MEM(Mem2Reg_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .Branch_MEM(Branch_MEM), .Uncondbranch_MEM(Uncondbranch_MEM),
    .ALUzero_MEM(ALUzero_MEM), .RD_MEM(RD_MEM), .ALUout_MEM(ALUout_MEM),
    .RegOutB_MEM(RegOutB_MEM), .PCtarget_MEM(PCtarget_MEM),
    .PCSrc(PCSrc), .PCtarget(PCtarget), .stall_MEM(stall_MEM),
    .RegWrite_WB(RegWrite_WB), .Mem2Reg_WB(Mem2Reg_WB), .RD_WB(RD_WB),
    .ALUout_WB(ALUout_WB), .MemData_WB(MemData_WB), .mem_err(mem_err),
    .dmem(dmem_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: m_busy = number of memory cycles already spent on the current access (0 = none).
  int          m_busy;
  logic        m_rw, m_m2r, m_err;
  logic [4:0]  m_rd;
  logic [63:0] m_alu, m_data;

  task automatic m_bubble();
    m_rw = 0; m_m2r = 0; m_rd = '0; m_alu = '0; m_data = '0;
  endtask

  task automatic m_take(input logic [63:0] data);
    m_rw = RegWrite_MEM; m_m2r = Mem2Reg_MEM; m_rd = RD_MEM; m_alu = ALUout_MEM; m_data = data;
  endtask

  function automatic logic f_memop();
    return MemRead_MEM | MemWrite_MEM;
  endfunction

  function automatic logic f_aligned_op();
    return f_memop() && (ALUout_MEM % 8 == 0);
  endfunction

  always @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      m_busy = 0; m_err = 0; m_bubble();
    end else if (m_busy == 0) begin
      if (!f_memop()) m_take(64'd0);
      else if (!f_aligned_op()) begin m_bubble(); m_err = 1; end
      else begin m_bubble(); m_busy = 1; end
    end else if (dmem_bus.dmem_ack) begin
      m_take(MemRead_MEM ? dmem_bus.dmem_rdata : 64'd0);
      m_busy = 0;
    end else if (m_busy == TO) begin
      m_bubble(); m_err = 1; m_busy = 0;
    end else begin
      m_bubble(); m_busy = m_busy + 1;
    end
  end

  int   stall_cnt, we_cnt, req_cnt;
  logic e_req, e_stall;

  always @(negedge clk) begin
    if (resetl) begin
      e_req   = (m_busy != 0) || f_aligned_op();
      e_stall = (m_busy == 0) ? f_aligned_op() : (!dmem_bus.dmem_ack && m_busy < TO);
      chk("pcsrc", 64'(PCSrc), 64'(Uncondbranch_MEM | (Branch_MEM & ALUzero_MEM)));
      chk("pctarget", PCtarget, PCtarget_MEM);
      chk("dmem_req", 64'(dmem_bus.dmem_req), 64'(e_req));
      chk("stall", 64'(stall_MEM), 64'(e_stall));
      if (e_req) begin
        chk("dmem_we", 64'(dmem_bus.dmem_we), 64'(MemWrite_MEM));
        chk("dmem_addr", dmem_bus.dmem_addr, ALUout_MEM);
        chk("dmem_wdata", dmem_bus.dmem_wdata, RegOutB_MEM);
      end
      chk("regwrite_wb", 64'(RegWrite_WB), 64'(m_rw));
      chk("mem2reg_wb", 64'(Mem2Reg_WB), 64'(m_m2r));
      chk("rd_wb", 64'(RD_WB), 64'(m_rd));
      chk("aluout_wb", ALUout_WB, m_alu);
      chk("memdata_wb", MemData_WB, m_data);
      chk("mem_err", 64'(mem_err), 64'(m_err));
      stall_cnt += int'(stall_MEM);
      we_cnt    += int'(dmem_bus.dmem_req & dmem_bus.dmem_we);
      req_cnt   += int'(dmem_bus.dmem_req);
    end
  end

  task automatic nop();
    RegWrite_MEM = 0; Mem2Reg_MEM = 0; MemRead_MEM = 0; MemWrite_MEM = 0;
    Branch_MEM = 0; Uncondbranch_MEM = 0; ALUzero_MEM = 0;
    RD_MEM = '0; ALUout_MEM = '0; RegOutB_MEM = '0; PCtarget_MEM = '0;
    dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = '0;
  endtask

  task automatic clr_cnt();
    stall_cnt = 0; we_cnt = 0; req_cnt = 0;
  endtask

  task automatic do_reset();
    resetl = 0; nop();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", 64'(RegWrite_WB), 64'd0);
    chk("rst_rd", 64'(RD_WB), 64'd0);
    chk("rst_alu", ALUout_WB, 64'd0);
    chk("rst_err", 64'(mem_err), 64'd0);
    chk("rst_req", 64'(dmem_bus.dmem_req), 64'd0);
    resetl = 1;
    @(posedge clk); #1;
  endtask

  // Memory access; ack arrives in cycle 'delay' after the request cycle (never if delay > TO).
  task automatic mem_access(input logic ld, input logic [63:0] addr, input logic [63:0] wd,
                            input int delay, input logic [63:0] rdata, input logic [4:0] rd);
    MemRead_MEM = ld; MemWrite_MEM = ~ld; RegWrite_MEM = ld; Mem2Reg_MEM = ld;
    RD_MEM = rd; ALUout_MEM = addr; RegOutB_MEM = wd;
    for (int k = 0; k <= TO; k++) begin
      dmem_bus.dmem_ack   = (k == delay);
      dmem_bus.dmem_rdata = (k == delay) ? rdata : 64'hBAD0_BAD0;
      @(posedge clk); #1;
      if (k == delay) break;
    end
    nop();
  endtask

  initial begin
    nop(); clr_cnt();
    m_busy = 0; m_err = 0; m_bubble();
    do_reset();

    // R-type
    clr_cnt();
    RegWrite_MEM = 1; RD_MEM = 5'd5; ALUout_MEM = 64'h2A;
    @(posedge clk); #1;
    chk("rtype_rw", 64'(RegWrite_WB), 64'd1);
    chk("rtype_rd", 64'(RD_WB), 64'd5);
    chk("rtype_alu", ALUout_WB, 64'h2A);
    nop();
    @(posedge clk); #1;
    chk("rtype_stall", 64'(stall_cnt), 64'd0);

    // Load with ack 3 cycles after the request
    clr_cnt();
    mem_access(1'b1, 64'h100, 64'd0, 3, 64'hDEADBEEF, 5'd7);
    chk("ld_memdata", MemData_WB, 64'hDEADBEEF);
    chk("ld_m2r", 64'(Mem2Reg_WB), 64'd1);
    chk("ld_rd", 64'(RD_WB), 64'd7);
    chk("ld_stall_cycles", 64'(stall_cnt), 64'd3);

    // Back-to-back: store with immediate ack
    clr_cnt();
    mem_access(1'b0, 64'h08, 64'h55, 1, 64'h0, 5'd0);
    chk("st_we_cycles", 64'(we_cnt), 64'd2);
    chk("st_rw", 64'(RegWrite_WB), 64'd0);
    chk("st_memdata", MemData_WB, 64'd0);
    chk("st_err", 64'(mem_err), 64'd0);

    // Misaligned load
    clr_cnt();
    MemRead_MEM = 1; RegWrite_MEM = 1; Mem2Reg_MEM = 1; RD_MEM = 5'd3; ALUout_MEM = 64'h103;
    @(posedge clk); #1;
    chk("mis_err", 64'(mem_err), 64'd1);
    chk("mis_rw", 64'(RegWrite_WB), 64'd0);
    chk("mis_req", 64'(req_cnt), 64'd0);
    chk("mis_stall", 64'(stall_cnt), 64'd0);
    nop();
    @(posedge clk); #1;
    chk("mis_sticky", 64'(mem_err), 64'd1);

    // Timeout
    do_reset();
    clr_cnt();
    mem_access(1'b1, 64'h200, 64'd0, TO + 5, 64'h0, 5'd9);
    chk("to_err", 64'(mem_err), 64'd1);
    chk("to_stall_cycles", 64'(stall_cnt), 64'd16);
    chk("to_rw", 64'(RegWrite_WB), 64'd0);
    chk("to_req_cycles", 64'(req_cnt), 64'd17);
    @(posedge clk); #1;

    // Branch resolution
    do_reset();
    Branch_MEM = 1; ALUzero_MEM = 1; PCtarget_MEM = 64'h40;
    #1;
    chk("br_taken", 64'(PCSrc), 64'd1);
    chk("br_target", PCtarget, 64'h40);
    ALUzero_MEM = 0; #1;
    chk("br_not_taken", 64'(PCSrc), 64'd0);
    Branch_MEM = 0; Uncondbranch_MEM = 1; #1;
    chk("br_uncond", 64'(PCSrc), 64'd1);
    @(posedge clk); #1;
    nop();

    // Reset mid-WAIT
    MemRead_MEM = 1; RegWrite_MEM = 1; Mem2Reg_MEM = 1; RD_MEM = 5'd4; ALUout_MEM = 64'h300;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_req_before", 64'(dmem_bus.dmem_req), 64'd1);
    resetl = 0; nop();
    #1;
    chk("mid_req", 64'(dmem_bus.dmem_req), 64'd0);
    chk("mid_stall", 64'(stall_MEM), 64'd0);
    chk("mid_wb_rw", 64'(RegWrite_WB), 64'd0);
    chk("mid_wb_rd", 64'(RD_WB), 64'd0);
    chk("mid_wb_data", MemData_WB, 64'd0);
    repeat (2) @(posedge clk);
    #1 resetl = 1;
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
